// File: rtl/axi_uart_pkg.sv
// Shared constants and FSM encoding for the AXI UARTLite transmit scheduler.
package axi_uart_pkg;

  localparam logic [31:0] TX_FIFO_OFS = 32'h4;
  localparam logic [31:0] STAT_OFS    = 32'h8;
  localparam logic [31:0] CTRL_OFS    = 32'hC;

  localparam int STAT_TX_FULL_BIT = 3;

  // Reset both FIFOs and leave interrupts disabled.
  localparam logic [31:0] CTRL_INIT = 32'h3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    INIT_AW, INIT_B, IDLE, RD_AR, RD_R, GAP, WR_AW, WR_B
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int C_NUM_REQ = 4,
  localparam int PW = $clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [C_NUM_REQ-1:0] grant
);

  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(C_NUM_REQ)) sum = sum - SW'(C_NUM_REQ);
      if (!found && req[sum[PW-1:0]]) begin
        grant[sum[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_uart_tx_sched.sv
// AXI4-Lite master sharing one UARTLite TX FIFO between C_NUM_REQ byte sources:
// init CTRL, round-robin grant, poll STAT while full, write one byte per AXI write.
module axi_uart_tx_sched
  import axi_uart_pkg::*;
#(
  parameter int          C_NUM_REQ       = 4,
  parameter logic [31:0] C_UART_BASEADDR = 32'h00000000,
  parameter int          C_POLL_GAP      = 16,
  localparam int C_S_AXI_ADDR_WIDTH = 32,
  localparam int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_NUM_REQ-1:0]            req_valid,
  input  logic [8*C_NUM_REQ-1:0]          req_data,
  output logic [C_NUM_REQ-1:0]            req_ready,
  output logic                            busy,
  output logic                            bus_err,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int PW = $clog2(C_NUM_REQ);
  localparam int GW = $clog2(C_POLL_GAP + 1);

  state_t        state;
  logic          issued;
  logic [7:0]    tx_byte;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_nxt;
  logic [GW-1:0] gap_cnt;
  logic [C_NUM_REQ-1:0] grant;
  logic          tx_full;
  logic          unused_rdata;

  rr_arbiter #(.C_NUM_REQ(C_NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < C_NUM_REQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign ptr_nxt      = (gidx == PW'(C_NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign req_ready    = (state == IDLE) ? grant : '0;
  assign busy         = (state != IDLE);
  assign M_AXI_ARADDR = C_UART_BASEADDR + STAT_OFS;
  // An errored STAT read counts as "not full" so a broken slave cannot stall us.
  assign tx_full      = M_AXI_RDATA[STAT_TX_FULL_BIT] && (M_AXI_RRESP == RESP_OKAY);
  assign unused_rdata = ^{M_AXI_RDATA[C_S_AXI_DATA_WIDTH-1:STAT_TX_FULL_BIT+1],
                          M_AXI_RDATA[STAT_TX_FULL_BIT-1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= INIT_AW;
      issued        <= 1'b0;
      tx_byte       <= '0;
      ptr           <= '0;
      gap_cnt       <= '0;
      bus_err       <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        INIT_AW, WR_AW: begin
          if (!issued) begin
            issued        <= 1'b1;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            if (state == INIT_AW) begin
              M_AXI_AWADDR <= C_UART_BASEADDR + CTRL_OFS;
              M_AXI_WDATA  <= CTRL_INIT;
              M_AXI_WSTRB  <= 4'hF;
            end else begin
              M_AXI_AWADDR <= C_UART_BASEADDR + TX_FIFO_OFS;
              M_AXI_WDATA  <= {24'b0, tx_byte};
              M_AXI_WSTRB  <= 4'b0001;
            end
          end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
            // Each channel is done once its VALID has already dropped or completes now.
            if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
              issued       <= 1'b0;
              M_AXI_BREADY <= 1'b1;
              state        <= (state == INIT_AW) ? INIT_B : WR_B;
            end
          end
        end
        INIT_B, WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) bus_err <= 1'b1;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (|req_valid) begin
            tx_byte       <= req_data[{gidx, 3'b000} +: 8];
            ptr           <= ptr_nxt;
            M_AXI_ARVALID <= 1'b1;
            state         <= RD_AR;
          end
        end
        RD_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_R;
          end
        end
        RD_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RRESP != RESP_OKAY) bus_err <= 1'b1;
            if (tx_full) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= WR_AW;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(C_POLL_GAP - 1)) begin
            M_AXI_ARVALID <= 1'b1;
            state         <= RD_AR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= INIT_AW;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_uart_tx_sched.sv
// Scoreboarded bench: directed requests, AXI-Lite slave model, write/protocol monitor.
module tb_axi_uart_tx_sched;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4060_0000;
  localparam int          GAPC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           busy, bus_err;
  logic [31:0]    M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [31:0]    M_AXI_RDATA = '0;
  logic [3:0]     M_AXI_WSTRB;
  logic           M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic           M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic           M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]     M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;

  axi_uart_tx_sched #(.C_NUM_REQ(N), .C_UART_BASEADDR(BASE), .C_POLL_GAP(GAPC)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .busy(busy), .bus_err(bus_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] stat_q[$];
  int          ar_cyc[$];
  int checks = 0, errors = 0;
  int cyc = 0, ar_count = 0, b_count = 0;
  int aw_delay = 0, w_delay = 0;
  bit bresp_err = 0;
  bit saw_w_first = 0, saw_aw_first = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_q.push_back(e);
  endtask

  // ---------------- AXI-Lite slave model ----------------
  logic ev_aw, ev_w, ev_ar, ev_r, ev_b;
  bit   got_aw = 0, got_w = 0;
  int   aw_cnt = 0, w_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      ev_aw = M_AXI_AWVALID && M_AXI_AWREADY;
      ev_w  = M_AXI_WVALID && M_AXI_WREADY;
      ev_ar = M_AXI_ARVALID && M_AXI_ARREADY;
      ev_r  = M_AXI_RVALID && M_AXI_RREADY;
      ev_b  = M_AXI_BVALID && M_AXI_BREADY;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0;  M_AXI_RVALID = 1'b0;
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (ev_aw) got_aw = 1;
        if (ev_w)  got_w = 1;
        if (ev_b)  M_AXI_BVALID = 1'b0;
        if (got_aw && got_w) begin
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP  = bresp_err ? 2'b10 : 2'b00;
          bresp_err = 0; got_aw = 0; got_w = 0;
        end
        if (ev_r) M_AXI_RVALID = 1'b0;
        if (ev_ar) begin
          M_AXI_RVALID = 1'b1;
          M_AXI_RRESP  = 2'b00;
          M_AXI_RDATA  = 32'h0;
          if (stat_q.size() != 0) M_AXI_RDATA = stat_q.pop_front();
        end
        aw_cnt = M_AXI_AWVALID ? aw_cnt + 1 : 0;
        w_cnt  = M_AXI_WVALID ? w_cnt + 1 : 0;
        M_AXI_AWREADY = (aw_delay == 0) || (M_AXI_AWVALID && aw_cnt >= aw_delay);
        M_AXI_WREADY  = (w_delay == 0) || (M_AXI_WVALID && w_cnt >= w_delay);
        M_AXI_ARREADY = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          have_aw = 0, have_w = 0;
  logic [31:0] cap_addr, cap_data, p_awaddr, p_wdata;
  logic [3:0]  cap_strb, p_wstrb;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  wr_t         e_pop;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        have_aw = 0; have_w = 0;
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (p_awv && !p_awr) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
        if (p_awv && p_awr)  chk("aw_drop", M_AXI_AWVALID, 1'b0);
        if (p_wv && !p_wr)   chk("w_hold", {M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB},
                                 {1'b1, p_wdata, p_wstrb});
        if (p_wv && p_wr)    chk("w_drop", M_AXI_WVALID, 1'b0);
        if (p_arv && !p_arr) chk("ar_hold", M_AXI_ARVALID, 1'b1);
        if (p_arv && p_arr)  chk("ar_drop", M_AXI_ARVALID, 1'b0);
        if (M_AXI_AWVALID && !M_AXI_WVALID) saw_w_first = 1;
        if (M_AXI_WVALID && !M_AXI_AWVALID) saw_aw_first = 1;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin have_aw = 1; cap_addr = M_AXI_AWADDR; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          have_w = 1; cap_data = M_AXI_WDATA; cap_strb = M_AXI_WSTRB;
        end
        if (have_aw && have_w) begin
          have_aw = 0; have_w = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {cap_addr, cap_data, cap_strb}, 0);
          end else begin
            e_pop = exp_q.pop_front();
            chk("axi_write", {cap_addr, cap_data, cap_strb}, {e_pop.addr, e_pop.data, e_pop.strb});
          end
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_count++;
          ar_cyc.push_back(cyc);
          chk("ar_addr", M_AXI_ARADDR, BASE + 32'h8);
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_count++;
        p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        p_wv = M_AXI_WVALID;   p_wr = M_AXI_WREADY;   p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 3000 && g == '0; i++) begin
      @(negedge clk);
      g = req_ready;
    end
    chk("grant_seen", (g != '0), 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 1'b0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    logic [N-1:0] g;
    @(posedge clk); #1;
    req_data[idx*8 +: 8] = b;
    req_valid[idx] = 1'b1;
    push_wr(BASE + 32'h4, {24'h0, b}, 4'b0001);
    wait_grant(g);
    chk("send_grant", g, N'(1) << idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0]   rr_byte[5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    int b0, a0;

    // reset state, then CTRL init write
    repeat (3) @(negedge clk);
    chk("reset_outs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                       M_AXI_RREADY, req_ready, bus_err, busy}, {5'b0, 4'b0, 1'b0, 1'b1});
    push_wr(BASE + 32'hC, 32'h3, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();

    // round-robin with all four held
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    for (int k = 0; k < 5; k++) push_wr(BASE + 32'h4, {24'h0, rr_byte[k]}, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", g, rr_exp[k]);
      @(negedge clk);
      chk("ready_pulse", req_ready, '0);
    end
    req_valid = '0;
    wait_idle();

    // STAT full three times; req2 must wait behind req1
    stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h8);
    stat_q.push_back(32'h0);
    req_data[15:8] = 8'h52;
    req_data[23:16] = 8'h53;
    push_wr(BASE + 32'h4, 32'h52, 4'b0001);
    push_wr(BASE + 32'h4, 32'h53, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0110;
    wait_grant(g);
    chk("poll_grant1", g, 4'b0010);
    a0 = ar_count;
    ar_cyc.delete();
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant(g);
    chk("poll_grant2", g, 4'b0100);
    chk("poll_ar_count", ar_count - a0, 4);
    chk("poll_ar_cyc_n", ar_cyc.size(), 4);
    for (int i = 1; i < ar_cyc.size(); i++)
      chk("poll_spacing", ar_cyc[i] - ar_cyc[i-1], GAPC + 2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // AW late, then W late
    aw_delay = 3; w_delay = 0;
    saw_w_first = 0; saw_aw_first = 0;
    b0 = b_count;
    send(3, 8'h61);
    wait_idle();
    chk("skew_aw_b_count", b_count - b0, 1);
    chk("skew_aw_wdrop_first", saw_w_first, 1'b1);
    aw_delay = 0; w_delay = 3;
    saw_w_first = 0; saw_aw_first = 0;
    b0 = b_count;
    send(0, 8'h62);
    wait_idle();
    chk("skew_w_b_count", b_count - b0, 1);
    chk("skew_w_awdrop_first", saw_aw_first, 1'b1);
    w_delay = 0;

    // SLVERR on a TX write
    chk("bus_err_clear", bus_err, 1'b0);
    bresp_err = 1;
    send(1, 8'h71);
    wait_idle();
    chk("bus_err_set", bus_err, 1'b1);
    send(2, 8'h72);
    wait_idle();
    chk("bus_err_sticky", bus_err, 1'b1);

    // reset while stalled in WR_AW
    aw_delay = 20;
    @(posedge clk); #1;
    req_data[7:0] = 8'h81;
    req_valid[0] = 1'b1;
    wait_grant(g);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int i = 0; i < 100 && !M_AXI_AWVALID; i++) @(negedge clk);
    chk("in_wr_aw", M_AXI_AWVALID, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clear", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                          M_AXI_RREADY, busy, bus_err}, 7'b0000010);
    aw_delay = 0;
    repeat (2) @(negedge clk);
    push_wr(BASE + 32'hC, 32'h3, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();
    chk("bus_err_after_rst", bus_err, 1'b0);
    send(2, 8'h91);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
